// File: rtl/key_io_responder.sv
// Memory-mapped KEY pushbutton responder: synchronises and debounces the keys,
// exposes KDATA/KCTRL registers on the data port and raises a level interrupt.
module key_io_responder #(
    parameter int unsigned       DBITS           = 32,
    parameter int unsigned       KEY_BITS        = 4,
    parameter logic [DBITS-1:0]  ADDR_KDATA      = DBITS'(32'hF0000010),
    parameter logic [DBITS-1:0]  ADDR_KCTRL      = DBITS'(32'hF0000110),
    parameter int unsigned       DEBOUNCE_CYCLES = 3,
    parameter int unsigned       CNT_BITS        = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [KEY_BITS-1:0] KEY,
    input  logic [DBITS-1:0]    addrIn,
    input  logic                isLoad,
    input  logic                isStore,
    input  logic [DBITS-1:0]    dataIn,
    output logic [DBITS-1:0]    dataOut,
    output logic                hit,
    output logic                intr
);

    localparam logic [CNT_BITS-1:0] CNT_LAST = CNT_BITS'(DEBOUNCE_CYCLES - 1);

    logic [KEY_BITS-1:0] r_sync1;
    logic [KEY_BITS-1:0] r_sync2;
    logic [KEY_BITS-1:0] r_key;
    logic [KEY_BITS-1:0] w_key_next;
    logic [CNT_BITS-1:0] r_cnt      [KEY_BITS];
    logic [CNT_BITS-1:0] w_cnt_next [KEY_BITS];

    logic r_ready;
    logic r_overrun;
    logic r_ie;

    logic w_hit_kdata;
    logic w_hit_kctrl;
    logic w_rd_kdata;
    logic w_wr_kctrl;
    logic w_change;
    logic [DBITS-1:0] w_kdata_val;
    logic [DBITS-1:0] w_kctrl_val;
    logic w_unused_data;

    assign w_hit_kdata = (addrIn == ADDR_KDATA);
    assign w_hit_kctrl = (addrIn == ADDR_KCTRL);
    assign w_rd_kdata  = isLoad && w_hit_kdata;
    assign w_wr_kctrl  = isStore && w_hit_kctrl;
    assign w_change    = |(w_key_next ^ r_key);

    assign w_kdata_val = DBITS'(r_key);
    assign w_kctrl_val = DBITS'({r_ie, 1'b0, r_overrun, 1'b0, r_ready});

    // Only bits 2 and 4 of store data have meaning in KCTRL.
    assign w_unused_data = ^{dataIn[DBITS-1:5], dataIn[3], dataIn[1:0]};

    // Per-key debounce: accept a new level only after it has persisted.
    always_comb begin
        w_key_next = r_key;
        for (int i = 0; i < int'(KEY_BITS); i++) begin
            w_cnt_next[i] = '0;
            if (r_sync2[i] != r_key[i]) begin
                if (r_cnt[i] == CNT_LAST) begin
                    w_key_next[i] = r_sync2[i];
                end else begin
                    w_cnt_next[i] = r_cnt[i] + CNT_BITS'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_key   <= '0;
            for (int i = 0; i < int'(KEY_BITS); i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_sync1 <= ~KEY;
            r_sync2 <= r_sync1;
            r_key   <= w_key_next;
            for (int i = 0; i < int'(KEY_BITS); i++) begin
                r_cnt[i] <= w_cnt_next[i];
            end
        end
    end

    // A key event outranks both a concurrent KDATA read and an Overrun-clearing store.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ready   <= 1'b0;
            r_overrun <= 1'b0;
            r_ie      <= 1'b0;
        end else begin
            if (w_change && r_ready && !w_rd_kdata) begin
                r_overrun <= 1'b1;
            end else if (w_wr_kctrl && !dataIn[2]) begin
                r_overrun <= 1'b0;
            end

            if (w_change) begin
                r_ready <= 1'b1;
            end else if (w_rd_kdata) begin
                r_ready <= 1'b0;
            end

            if (w_wr_kctrl) begin
                r_ie <= dataIn[4];
            end
        end
    end

    always_comb begin
        dataOut = '0;
        if (isLoad) begin
            if (w_hit_kdata) begin
                dataOut = w_kdata_val;
            end else if (w_hit_kctrl) begin
                dataOut = w_kctrl_val;
            end
        end
    end

    assign hit  = w_hit_kdata || w_hit_kctrl;
    assign intr = r_ready && r_ie;

endmodule

// File: tb/tb_key_io_responder.sv
// Vector-table bench for key_io_responder with a scoreboard queue of expected
// dataOut/hit/intr per cycle; the reset-during-debounce case is written out by hand.
module tb_key_io_responder;

    localparam logic [31:0] KD = 32'hF0000010;
    localparam logic [31:0] KC = 32'hF0000110;
    localparam logic [31:0] NA = 32'hF0000014;

    typedef struct {
        logic        rst;
        logic [3:0]  key;
        logic        ld;
        logic        st;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] dout;
        logic        hit;
        logic        intr;
    } vec_t;

    logic        clk;
    logic        reset;
    logic [3:0]  KEY;
    logic [31:0] addrIn;
    logic        isLoad;
    logic        isStore;
    logic [31:0] dataIn;
    logic [31:0] dataOut;
    logic        hit;
    logic        intr;

    vec_t vecs[$];
    vec_t sb[$];
    int   checks;
    int   failures;
    int   step_no;

    key_io_responder dut (
        .clk     (clk),
        .reset   (reset),
        .KEY     (KEY),
        .addrIn  (addrIn),
        .isLoad  (isLoad),
        .isStore (isStore),
        .dataIn  (dataIn),
        .dataOut (dataOut),
        .hit     (hit),
        .intr    (intr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired at step %0d", step_no);
        $fatal(1, "watchdog");
    end

    function automatic vec_t mk(input logic rst, input logic [3:0] key, input logic ld,
                                input logic st, input logic [31:0] addr, input logic [31:0] wd,
                                input logic [31:0] dout, input logic h, input logic irq);
        vec_t v;
        v.rst = rst; v.key = key; v.ld = ld; v.st = st; v.addr = addr; v.wd = wd;
        v.dout = dout; v.hit = h; v.intr = irq;
        return v;
    endfunction

    task automatic add(input logic rst, input logic [3:0] key, input logic ld, input logic st,
                       input logic [31:0] addr, input logic [31:0] wd,
                       input logic [31:0] dout, input logic h, input logic irq);
        vecs.push_back(mk(rst, key, ld, st, addr, wd, dout, h, irq));
    endtask

    // Drive one cycle's inputs after the edge, observe mid-cycle, compare against the queue head.
    task automatic step(input vec_t v);
        vec_t e;
        @(posedge clk);
        #1;
        reset   = v.rst;
        KEY     = v.key;
        isLoad  = v.ld;
        isStore = v.st;
        addrIn  = v.addr;
        dataIn  = v.wd;
        sb.push_back(v);
        @(negedge clk);
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_empty step %0d", step_no);
        end else begin
            e = sb.pop_front();
            checks++;
            if (dataOut !== e.dout) begin
                failures++;
                $display("FAIL dataOut step %0d got %h want %h", step_no, dataOut, e.dout);
            end
            checks++;
            if (hit !== e.hit) begin
                failures++;
                $display("FAIL hit step %0d got %b want %b", step_no, hit, e.hit);
            end
            checks++;
            if (intr !== e.intr) begin
                failures++;
                $display("FAIL intr step %0d got %b want %b", step_no, intr, e.intr);
            end
        end
        step_no++;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        step_no  = 0;
        reset    = 1'b1;
        KEY      = 4'hF;
        addrIn   = '0;
        isLoad   = 1'b0;
        isStore  = 1'b0;
        dataIn   = '0;

        // Reset cycle, then KEY[0] pressed: keyState/Ready appear after edge 5.
        add(1, 4'hF, 1, 0, KC, 0, 0, 1, 0);
        add(0, 4'hE, 1, 0, NA, 0, 0, 0, 0);
        add(0, 4'hE, 0, 0, KD, 0, 0, 1, 0);
        add(0, 4'hE, 0, 1, KD, 32'hFFFF_FFFF, 0, 1, 0);
        add(0, 4'hE, 1, 0, KD, 0, 0, 1, 0);
        add(0, 4'hE, 1, 0, KC, 0, 0, 1, 0);
        add(0, 4'hE, 1, 0, KD, 0, 1, 1, 0);
        add(0, 4'hE, 1, 0, KC, 0, 0, 1, 0);
        // Two-cycle glitch on KEY[1] is rejected.
        for (int i = 0; i < 2; i++) add(0, 4'hC, 1, 0, KD, 0, 1, 1, 0);
        add(0, 4'hE, 1, 0, KC, 0, 0, 1, 0);
        add(0, 4'hE, 1, 0, KD, 0, 1, 1, 0);
        add(0, 4'hE, 1, 0, KC, 0, 0, 1, 0);
        add(0, 4'hE, 1, 0, KD, 0, 1, 1, 0);
        // Release then re-press KEY[0] without reading KDATA -> Overrun.
        add(0, 4'hF, 1, 0, KD, 0, 1, 1, 0);
        for (int i = 0; i < 4; i++) add(0, 4'hF, 1, 0, KC, 0, 0, 1, 0);
        for (int i = 0; i < 5; i++) add(0, 4'hE, 1, 0, KC, 0, 1, 1, 0);
        add(0, 4'hE, 1, 0, KC, 0, 32'h5, 1, 0);
        add(0, 4'hE, 0, 1, KC, 0, 0, 1, 0);
        add(0, 4'hE, 1, 0, KC, 0, 32'h1, 1, 0);
        // Enable interrupts, then a press on KEY[2] (KEY[0] released together).
        add(0, 4'hE, 1, 0, KD, 0, 1, 1, 0);
        add(0, 4'hE, 0, 1, KC, 32'h10, 0, 1, 0);
        for (int i = 0; i < 5; i++) add(0, 4'hB, 0, 0, 0, 0, 0, 0, 0);
        add(0, 4'hB, 1, 0, KD, 0, 32'h4, 1, 1);
        add(0, 4'hB, 1, 0, KC, 0, 32'h10, 1, 0);
        // Ready left set, then a KDATA read coincides with the next change.
        for (int i = 0; i < 5; i++) add(0, 4'hF, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) add(0, 4'h7, 0, 0, 0, 0, 0, 0, 1);
        add(0, 4'h7, 1, 0, KD, 0, 32'h0, 1, 1);
        add(0, 4'h7, 1, 0, KC, 0, 32'h11, 1, 1);
        add(0, 4'h7, 1, 0, KD, 0, 32'h8, 1, 1);
        add(0, 4'h7, 1, 0, KC, 0, 32'h10, 1, 0);
        // Load+store in one cycle sees the old value; KDATA ignores stores.
        add(0, 4'h7, 1, 1, KC, 0, 32'h10, 1, 0);
        add(0, 4'h7, 1, 0, KC, 0, 0, 1, 0);
        add(0, 4'h7, 0, 1, KD, 32'hFFFF_FFFF, 0, 1, 0);
        add(0, 4'h7, 1, 0, KC, 0, 0, 1, 0);
        // Overrun set beats a same-edge clearing store; writing 1 keeps it.
        for (int i = 0; i < 5; i++) add(0, 4'hF, 1, 0, KC, 0, 0, 1, 0);
        add(0, 4'hF, 1, 0, KC, 0, 32'h1, 1, 0);
        for (int i = 0; i < 4; i++) add(0, 4'h7, 1, 0, KC, 0, 32'h1, 1, 0);
        add(0, 4'h7, 0, 1, KC, 0, 0, 1, 0);
        add(0, 4'h7, 1, 0, KC, 0, 32'h5, 1, 0);
        add(0, 4'h7, 0, 1, KC, 32'h4, 0, 1, 0);
        add(0, 4'h7, 1, 0, KC, 0, 32'h5, 1, 0);
        add(0, 4'h7, 0, 1, KC, 0, 0, 1, 0);
        add(0, 4'h7, 1, 0, KC, 0, 32'h1, 1, 0);
        add(0, 4'h7, 1, 0, KD, 0, 32'h8, 1, 0);
        add(0, 4'h7, 1, 0, KC, 0, 0, 1, 0);

        foreach (vecs[i]) step(vecs[i]);

        // Reset arriving with KEY[3]'s count at 2 discards it; IE is cleared too.
        step(mk(1, 4'hF, 1, 0, KC, 0, 0, 1, 0));
        step(mk(0, 4'h7, 0, 1, KC, 32'h10, 0, 1, 0));
        step(mk(0, 4'h7, 0, 0, 0, 0, 0, 0, 0));
        step(mk(0, 4'h7, 0, 0, 0, 0, 0, 0, 0));
        step(mk(0, 4'h7, 1, 0, KC, 0, 32'h10, 1, 0));
        step(mk(1, 4'h7, 0, 0, 0, 0, 0, 0, 0));
        step(mk(0, 4'h7, 1, 0, KC, 0, 0, 1, 0));
        for (int i = 0; i < 4; i++) step(mk(0, 4'h7, 1, 0, KD, 0, 0, 1, 0));
        step(mk(0, 4'h7, 1, 0, KC, 0, 32'h1, 1, 0));
        step(mk(0, 4'h7, 1, 0, KD, 0, 32'h8, 1, 0));

        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_leftover got %0d want 0", sb.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
